// File: rtl/ex_muldiv_unit.sv
// Iterative 32-step MIPS MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Ports: clk, reset (async active-low), start/op/rs_in/rt_in request an
// operation; hi_we/lo_we/wdata service MTHI/MTLO; busy, done, div_by_zero,
// hi_out and lo_out report status and the HI/LO contents.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_in,
    input  logic [XLEN-1:0] rt_in,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]        op_q;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_a;
    logic              neg_b;
    logic [CW-1:0]     cnt;
    // {upper, lower}: product/multiplier for MUL, remainder/quotient for DIV
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              dbz_q;

    logic              idle;
    logic              last;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   rs_orig;
    logic              b_zero;

    assign idle = (state == S_IDLE) || (state == S_DONE);
    assign last = (cnt == CW'(ITER - 1));

    // Sign flags only exist for the signed encodings (op[0]=1).
    assign sa    = op[0] & rs_in[XLEN-1];
    assign sb    = op[0] & rt_in[XLEN-1];
    assign abs_a = sa ? (~rs_in + 1'b1) : rs_in;
    assign abs_b = sb ? (~rt_in + 1'b1) : rt_in;

    // Shift-add: add multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole pair right.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor; the top bit of the difference is the borrow.
    assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_next = div_diff[XLEN]
                    ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    assign quo_fix  = (neg_a ^ neg_b) ? (~acc[XLEN-1:0] + 1'b1)
                                      : acc[XLEN-1:0];
    assign rem_fix  = neg_a ? (~acc[2*XLEN-1:XLEN] + 1'b1)
                            : acc[2*XLEN-1:XLEN];
    assign rs_orig  = neg_a ? (~mag_a + 1'b1) : mag_a;
    assign b_zero   = (mag_b == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = op[1] ? S_DIV : S_MUL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX:   state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (hi_we) begin
                        hi_q <= wdata;
                    end
                    if (lo_we) begin
                        lo_q <= wdata;
                    end
                    if (start) begin
                        op_q  <= op;
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg_a <= sa;
                        neg_b <= sb;
                        cnt   <= '0;
                        dbz_q <= 1'b0;
                        acc   <= op[1] ? {{XLEN{1'b0}}, abs_a}
                                       : {{XLEN{1'b0}}, abs_b};
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!op_q[1]) begin
                        hi_q <= prod_fix[2*XLEN-1:XLEN];
                        lo_q <= prod_fix[XLEN-1:0];
                    end else if (b_zero) begin
                        hi_q  <= rs_orig;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        // 0x80000000 / -1 falls out naturally: the
                        // magnitude quotient negates back to itself.
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state == S_MUL) || (state == S_DIV)
                      || (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit.
// Expected HI/LO are queued at issue and popped when done pulses.
module tb_ex_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_in = '0;
    logic [31:0] rt_in = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];

    ex_muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_in       (rs_in),
        .rt_in       (rt_in),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        res_t r;
        logic [63:0] p;
        int sa;
        int sb;
        r = '0;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin
                p = {32'b0, a} * {32'b0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFFFFFF;
                    r.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    r.lo = 32'h80000000;
                    r.hi = 32'd0;
                end else begin
                    r.lo = sa / sb;
                    r.hi = sa % sb;
                end
            end
        endcase
        return r;
    endfunction

    // Drives one start cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input res_t e);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs_in = a;
        rt_in = b;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        rs_in = $urandom;
        rt_in = $urandom;
    endtask

    // Counts negedges since the start request; stops at 60 if done never comes.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, div_by_zero, hi_out, lo_out} !== 67'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
                     busy, done, div_by_zero, hi_out, lo_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_mul_div;
        int   lat;
        res_t e;
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h1, 1'b0});
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_start: got %b want 1", busy);
        end
        repeat (31) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_fix: busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(32, lat);
        tests++;
        if (lat != 34 || busy !== 1'b0) begin
            fails++;
            $display("FAIL multu_lat: got %0d busy=%b want 34 busy=0", lat, busy);
        end
        e = exp_q.pop_front();
        tests++;
        if ({hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL multu: hi=%h lo=%h want hi=%h lo=%h",
                     hi_out, lo_out, e.hi, e.lo);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got %b want 0", done);
        end
        issue(2'd1, 32'hFFFFFFFD, 32'd5, '{32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL mult: lat=%0d hi=%h lo=%h want 34 hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
        issue(2'd3, 32'hFFFFFFF9, 32'd2, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL div: lat=%0d hi=%h lo=%h want 34 hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
    endtask

    task automatic test_div_by_zero;
        int   lat;
        res_t e;
        issue(2'd2, 32'd100, 32'd0, '{32'h64, 32'hFFFFFFFF, 1'b1});
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL divu_zero: lat=%0d hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=1",
                     lat, hi_out, lo_out, div_by_zero, e.hi, e.lo);
        end
        issue(2'd2, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0});
        tests++;
        if (div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL dbz_clear: got %b want 0", div_by_zero);
        end
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL divu: lat=%0d hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=0",
                     lat, hi_out, lo_out, div_by_zero, e.hi, e.lo);
        end
    endtask

    task automatic test_start_ignored;
        int   lat;
        res_t e;
        issue(2'd0, 32'd6, 32'd7, '{32'd0, 32'd42, 1'b0});
        repeat (8) @(negedge clk);
        start = 1'b1;
        op    = 2'd2;
        rs_in = 32'd9;
        rt_in = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL start_ignored: lat=%0d hi=%h lo=%h want 34 hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL no_restart: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midop;
        int   lat;
        res_t e;
        issue(2'd0, 32'h1234, 32'h5678, model(2'd0, 32'h1234, 32'h5678));
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        void'(exp_q.pop_front());
        tests++;
        if ({busy, done, hi_out, lo_out} !== 66'd0) begin
            fails++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h want all 0",
                     busy, done, hi_out, lo_out);
        end
        @(negedge clk);
        reset = 1'b1;
        issue(2'd0, 32'd2, 32'd3, '{32'd0, 32'd6, 1'b0});
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL after_reset: lat=%0d hi=%h lo=%h want 34 hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
    endtask

    task automatic test_hilo_write;
        int   lat;
        res_t e;
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        tests++;
        if (hi_out !== 32'hA5A5A5A5 || lo_out !== 32'd6) begin
            fails++;
            $display("FAIL mthi: hi=%h lo=%h want hi=a5a5a5a5 lo=6", hi_out, lo_out);
        end
        issue(2'd0, 32'd3, 32'd4, '{32'd0, 32'd12, 1'b0});
        repeat (4) @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        lo_we = 1'b0;
        tests++;
        if (lo_out !== 32'd6 || hi_out !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL mtlo_busy: hi=%h lo=%h want hi=a5a5a5a5 lo=6", hi_out, lo_out);
        end
        wait_done(6, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL mtlo_busy_res: lat=%0d hi=%h lo=%h want hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        rs_in = 32'd5;
        rt_in = 32'd5;
        lo_we = 1'b1;
        wdata = 32'h12345678;
        exp_q.push_back('{32'd0, 32'd25, 1'b0});
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        tests++;
        if (lo_out !== 32'h12345678 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mtlo_start: lo=%h busy=%b want lo=12345678 busy=1",
                     lo_out, busy);
        end
        wait_done(1, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
            fails++;
            $display("FAIL mtlo_start_res: lat=%0d hi=%h lo=%h want hi=%h lo=%h",
                     lat, hi_out, lo_out, e.hi, e.lo);
        end
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0F0F0F0F;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        tests++;
        if (hi_out !== 32'h0F0F0F0F || lo_out !== 32'h0F0F0F0F) begin
            fails++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h want both 0f0f0f0f", hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back;
        int          lat;
        res_t        e;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (i == 0) begin
                o = 2'd3; a = 32'h80000000; b = 32'hFFFFFFFF;
            end else if (i == 1) begin
                o = 2'd3; a = 32'hFFFFFFF7; b = 32'd0;
            end else if (i == 2) begin
                o = 2'd1; a = 32'h80000000; b = 32'h80000000;
            end else if (i == 3) begin
                o = 2'd3; a = 32'd7; b = 32'hFFFFFFFE;
            end
            issue(o, a, b, model(o, a, b));
            wait_done(1, lat);
            e = exp_q.pop_front();
            tests++;
            if (lat != 34 || {hi_out, lo_out, div_by_zero} !== e) begin
                fails++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                         i, o, a, b, lat, hi_out, lo_out, div_by_zero,
                         e.hi, e.lo, e.dbz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_div();
        test_div_by_zero();
        test_start_ignored();
        test_reset_midop();
        test_hilo_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register's rs/rt operand outputs.
- Performs MIPS MULT/MULTU/DIV/DIVU as an iterative 32-step engine and writes the HI/LO registers.
- Asserts busy so the hazard logic stalls IF/ID and holds the ID/EX register while a multi-cycle operation runs.
- Also services MTHI/MTLO writes; MFHI/MFLO read hi_out/lo_out directly.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration cycles per operation; equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request an operation; sampled only when not busy
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs_in  in  32  operand A (multiplicand/dividend), from ID/EX reg_rs_out
- rt_in  in  32  operand B (multiplier/divisor), from ID/EX reg_rt_out
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO hold a new result
- div_by_zero  out  1  valid with done; the completed divide had rt=0
- hi_out  out  32  HI register
- lo_out  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi_out, lo_out, busy, done, div_by_zero, iteration counter and internal operands all 0.
  - Reset asserted mid-operation aborts it; no result is written.
- States: IDLE, MUL, DIV, FIX, DONE. DONE behaves like IDLE for start and writes, and lasts exactly one cycle.
- Accept:
  - In IDLE/DONE, start=1 at edge E0 latches op, |rs_in|, |rt_in| and sign flags (signed ops only) and clears the counter.
  - Next state is MUL (op[1]=0) or DIV (op[1]=1).
- MUL: one shift-add step per cycle on the unsigned magnitudes, producing a 64-bit product.
- DIV: one restoring step per cycle, producing a 32-bit quotient and remainder.
- Counter 0..31; after the 32nd step (edge E32) the state becomes FIX.
- FIX (edge E33) applies sign correction and writes HI/LO:
  - Signed multiply: 64-bit product negated when signs differ. HI=product[63:32], LO=product[31:0].
  - Signed divide: quotient truncates toward zero, negated when signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
  - Divide by zero (rt=0, DIVU or DIV): LO=0xFFFFFFFF, HI=original rs_in, div_by_zero=1.
  - Next state is DONE.
- Timing:
  - busy=1 in MUL/DIV/FIX, i.e. the cycles after E0 through E33.
  - done=1 and div_by_zero valid for the one cycle after E33.
  - Fixed latency: 34 edges from accept to result.
- start while busy is ignored; the operation in flight continues unchanged.
- hi_we/lo_we:
  - In IDLE/DONE, the write takes effect at the next edge.
  - While busy, writes are dropped.
  - A write and start on the same edge: the write takes effect, the operands are latched, and the later result overwrites HI/LO.
  - hi_we and lo_we together write wdata to both registers.
- Operands are captured at accept, so rs_in/rt_in may change freely while busy.
- div_by_zero is cleared on the next accept.
- Widths: all intermediate arithmetic is unsigned 64-bit; no X propagation from unused op encodings (all four are defined).

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 34 cycles; done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1 with done.
  - Next DIVU 100/7 -> LO=14, HI=2, div_by_zero=0.
- MULTU 6x7 accepted; start pulsed with DIVU 9/3 at cycle 10 -> second request ignored; final HI=0, LO=42 at cycle 34.
- Operation in flight; reset low at cycle 15 -> hi_out/lo_out/busy/done immediately 0.
  - After release, start MULTU 2x3 -> LO=6 after 34 cycles.
- MTHI wdata=0xA5A5A5A5 while idle -> hi_out=0xA5A5A5A5 next cycle.
  - MTLO while busy -> lo_out unchanged until the result write.
  - MTLO together with start -> write visible, then overwritten by the result.
